// File: rtl/gold_stone_drawer.sv
// gold_stone_drawer: rasterises one gold or stone sprite rectangle into the
// VGA adapter pixel-write port, one pixel per clock, then pulses the matching
// done and bumps the matching saturating placed-object count.
//
// Optional feature macro: GOLD_STONE_DRAWER_CLIP_EN
//   defined   -> off-screen pixels are still iterated but written with plot=0
//   undefined -> every pixel is plotted; x/y wrap by truncation to 8/7 bits
//
// Handshake: enable_draw_gold / enable_draw_stone are level requests that are
// sampled only in IDLE. The requester holds its enable until it sees the
// one-cycle *_done pulse. The drawer then waits in RELEASE until that enable
// is low, so a held enable can never start a second draw.
//
// dbg_state exposes the FSM state (0 IDLE, 1 DRAW, 2 DONE, 3 RELEASE).
module gold_stone_drawer #(
    parameter int         GOLD_W       = 8,
    parameter int         GOLD_H       = 8,
    parameter int         STONE_W      = 6,
    parameter int         STONE_H      = 6,
    parameter logic [2:0] GOLD_COLOUR  = 3'b110,
    parameter logic [2:0] STONE_COLOUR = 3'b111,
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable_draw_gold,
    input  logic       enable_draw_stone,
    input  logic [7:0] rand_x,
    input  logic [6:0] rand_y,
    input  logic       resetn_gold_stone,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       draw_gold_done,
    output logic       draw_stone_done,
    output logic [2:0] gold_count,
    output logic [2:0] stone_count,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DRAW    = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic [3:0] GOLD_W_LAST  = 4'(GOLD_W - 1);
    localparam logic [3:0] GOLD_H_LAST  = 4'(GOLD_H - 1);
    localparam logic [3:0] STONE_W_LAST = 4'(STONE_W - 1);
    localparam logic [3:0] STONE_H_LAST = 4'(STONE_H - 1);

    // Reject sprite/screen sizes the 4-bit counters and 8/7-bit coordinates
    // cannot represent.
    if (GOLD_W < 1 || GOLD_W > 16 || GOLD_H < 1 || GOLD_H > 16 ||
        STONE_W < 1 || STONE_W > 16 || STONE_H < 1 || STONE_H > 16 ||
        SCREEN_W < 1 || SCREEN_W > 256 || SCREEN_H < 1 || SCREEN_H > 128) begin : g_bad_param
        $error("gold_stone_drawer: parameter out of range");
    end

    logic [1:0] state, state_n;
    logic [3:0] cx, cx_n;
    logic [3:0] cy, cy_n;
    logic [7:0] ox, ox_n;
    logic [6:0] oy, oy_n;
    logic       is_gold, is_gold_n;
    logic       emit;
    logic       done_g;
    logic       done_s;
    logic [3:0] w_last;
    logic [3:0] h_last;
    logic       owner_en;
    logic       on_screen;
    logic [2:0] colour_n;

`ifdef GOLD_STONE_DRAWER_CLIP_EN
    logic [8:0] sum_x;
    logic [7:0] sum_y;
`else
    logic [7:0] sum_x;
    logic [6:0] sum_y;
`endif

    // Next-state, scan counters and pixel emission for the pixel shown next cycle
    always_comb begin
        state_n   = state;
        cx_n      = cx;
        cy_n      = cy;
        ox_n      = ox;
        oy_n      = oy;
        is_gold_n = is_gold;
        emit      = 1'b0;
        done_g    = 1'b0;
        done_s    = 1'b0;
        w_last    = is_gold ? GOLD_W_LAST : STONE_W_LAST;
        h_last    = is_gold ? GOLD_H_LAST : STONE_H_LAST;
        owner_en  = is_gold ? enable_draw_gold : enable_draw_stone;

        case (state)
            IDLE: begin
                if (enable_draw_gold || enable_draw_stone) begin
                    // Gold wins when both requests arrive together.
                    ox_n      = rand_x;
                    oy_n      = rand_y;
                    is_gold_n = enable_draw_gold;
                    cx_n      = 4'd0;
                    cy_n      = 4'd0;
                    emit      = 1'b1;
                    state_n   = DRAW;
                end
            end
            DRAW: begin
                if (cx == w_last && cy == h_last) begin
                    done_g  = is_gold;
                    done_s  = !is_gold;
                    state_n = DONE;
                end else begin
                    emit = 1'b1;
                    if (cx == w_last) begin
                        cx_n = 4'd0;
                        cy_n = cy + 4'd1;
                    end else begin
                        cx_n = cx + 4'd1;
                    end
                end
            end
            DONE: begin
                state_n = RELEASE;
            end
            RELEASE: begin
                if (!owner_en) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Pixel coordinate and visibility of the pixel selected above
    always_comb begin
`ifdef GOLD_STONE_DRAWER_CLIP_EN
        sum_x     = {1'b0, ox_n} + {5'b0, cx_n};
        sum_y     = {1'b0, oy_n} + {4'b0, cy_n};
        on_screen = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
`else
        sum_x     = ox_n + {4'b0, cx_n};
        sum_y     = oy_n + {3'b0, cy_n};
        on_screen = 1'b1;
`endif
        colour_n = is_gold_n ? GOLD_COLOUR : STONE_COLOUR;
    end

    // FSM, scan counters, latched origin/type and registered pixel port
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= IDLE;
            cx              <= 4'd0;
            cy              <= 4'd0;
            ox              <= 8'd0;
            oy              <= 7'd0;
            is_gold         <= 1'b0;
            x               <= 8'd0;
            y               <= 7'd0;
            colour          <= 3'd0;
            plot            <= 1'b0;
            draw_gold_done  <= 1'b0;
            draw_stone_done <= 1'b0;
        end else begin
            state           <= state_n;
            cx              <= cx_n;
            cy              <= cy_n;
            ox              <= ox_n;
            oy              <= oy_n;
            is_gold         <= is_gold_n;
            plot            <= emit && on_screen;
            draw_gold_done  <= done_g;
            draw_stone_done <= done_s;
            // Coordinates and colour only move when a pixel is actually written.
            if (emit && on_screen) begin
                x      <= sum_x[7:0];
                y      <= sum_y[6:0];
                colour <= colour_n;
            end
        end
    end

    // Saturating placed-object counts; the count clear beats a same-edge increment
    always_ff @(posedge clk) begin
        if (!resetn || !resetn_gold_stone) begin
            gold_count  <= 3'd0;
            stone_count <= 3'd0;
        end else begin
            if (done_g && gold_count != 3'd7) begin
                gold_count <= gold_count + 3'd1;
            end
            if (done_s && stone_count != 3'd7) begin
                stone_count <= stone_count + 3'd1;
            end
        end
    end

    assign dbg_state = state;

endmodule
